// File: rtl/modn_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: count-direction encoding
// and the parameter legality check used by the counter's elaboration assertion.
package modn_cnt_pkg;

    typedef enum logic {
        CNT_MODE_DOWN = 1'b0,
        CNT_MODE_UP   = 1'b1
    } cnt_mode_e;

    // The width must hold every count value 0..modulus-1, and the step must stay below the modulus.
    function automatic bit cnt_params_legal(input longint modulus, input longint width,
                                            input longint step);
        return (modulus >= 2) && (modulus <= 65536) &&
               (step >= 1) && (step < modulus) &&
               (width >= 1) && (width <= 32) &&
               ((longint'(1) << width) >= modulus);
    endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// Control/status bundle of one modulo-N counter digit. The master drives the
// controls and observes the count; the slave is the counter itself.
interface modn_updown_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             cin;
    logic             load;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             co;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, cin, load, mode, data_in,
        input  count, tc, co, wrap, load_err
    );

    modport slave (
        input  en, cin, load, mode, data_in,
        output count, tc, co, wrap, load_err
    );

endinterface

// File: rtl/modn_updown_counter_step_calc.sv
// Next-count and boundary detection for one enabled step of the counter.
// Build option MODN_CNT_SATURATE_EN: clamp at the range ends instead of wrapping.
module modn_step_calc
    import modn_cnt_pkg::*;
#(
    parameter int MODULUS = 13,
    parameter int WIDTH   = $clog2(MODULUS),
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             will_wrap
);

    // One guard bit keeps count+STEP and count+MODULUS-STEP from overflowing.
    localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] LAST_X = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] count_x;
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] next_x;

    always_comb begin
        count_x   = {1'b0, count};
        sum_x     = count_x + STEP_X;
        next_x    = '0;
        will_wrap = 1'b0;
        if (mode == CNT_MODE_UP) begin
            will_wrap = (sum_x >= MOD_X);
`ifdef MODN_CNT_SATURATE_EN
            next_x = will_wrap ? LAST_X : sum_x;
`else
            next_x = will_wrap ? (sum_x - MOD_X) : sum_x;
`endif
        end else begin
            will_wrap = (count_x < STEP_X);
`ifdef MODN_CNT_SATURATE_EN
            next_x = will_wrap ? '0 : (count_x - STEP_X);
`else
            next_x = will_wrap ? (count_x + MOD_X - STEP_X) : (count_x - STEP_X);
`endif
        end
        next_count = next_x[WIDTH-1:0];
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter digit with load, enable, programmable step and
// cascade carry. Build option MODN_CNT_SATURATE_EN selects clamping over wrap-around.
module modn_updown_counter
    import modn_cnt_pkg::*;
#(
    parameter int MODULUS = 13,
    parameter int WIDTH   = $clog2(MODULUS),
    parameter int STEP    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    modn_updown_counter_if.slave cnt_if
);

    localparam logic [WIDTH:0]   MOD_X     = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LAST      = WIDTH'(MODULUS - 1);
    localparam bit               PARAMS_OK = cnt_params_legal(MODULUS, WIDTH, STEP);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             load_err_q;
    logic [WIDTH-1:0] next_count;
    logic             will_wrap;
    logic             step_en;

    assign step_en = cnt_if.en & cnt_if.cin;

    // The same boundary flag drives the registered step and the combinational tc.
    modn_step_calc #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH),
        .STEP    (STEP)
    ) u_step_calc (
        .count      (count_q),
        .mode       (cnt_if.mode),
        .next_count (next_count),
        .will_wrap  (will_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else if (cnt_if.load) begin
            wrap_q <= 1'b0;
            if ({1'b0, cnt_if.data_in} >= MOD_X) begin
                count_q    <= LAST;
                load_err_q <= 1'b1;
            end else begin
                count_q    <= cnt_if.data_in;
                load_err_q <= 1'b0;
            end
        end else if (step_en) begin
            count_q    <= next_count;
            wrap_q     <= will_wrap;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end
    end

    assign cnt_if.count    = count_q;
    assign cnt_if.tc       = will_wrap;
    assign cnt_if.co       = step_en & will_wrap;
    assign cnt_if.wrap     = wrap_q;
    assign cnt_if.load_err = load_err_q;

    param_legal_a: assert property (@(posedge clk)
        PARAMS_OK && ($bits(cnt_if.data_in) == WIDTH));

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: mod-13/step-1, mod-10/step-3 and a mod-10/mod-6
// cascade, driven by directed and random stimulus against an arithmetic model.
module tb_modn_updown_counter;

    typedef struct {
        int cnt;
        bit wrap;
        bit lerr;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    mdl_t m13, m10, mlo, mhi;

    always #5 clk = ~clk;

    modn_updown_counter_if #(.WIDTH(4)) i13 ();
    modn_updown_counter_if #(.WIDTH(4)) i10 ();
    modn_updown_counter_if #(.WIDTH(4)) i_lo ();
    modn_updown_counter_if #(.WIDTH(3)) i_hi ();

    assign i_hi.cin = i_lo.co;

    modn_updown_counter #(.MODULUS(13), .STEP(1)) u13 (.clk(clk), .rst(rst), .cnt_if(i13.slave));
    modn_updown_counter #(.MODULUS(10), .STEP(3)) u10 (.clk(clk), .rst(rst), .cnt_if(i10.slave));
    modn_updown_counter #(.MODULUS(10), .STEP(1)) u_lo (.clk(clk), .rst(rst), .cnt_if(i_lo.slave));
    modn_updown_counter #(.MODULUS(6),  .STEP(1)) u_hi (.clk(clk), .rst(rst), .cnt_if(i_hi.slave));

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Boundary: the next step in this direction leaves the range 0..m-1.
    function automatic bit mdl_tc(int c, int m, int st, bit up);
        return up ? (c + st >= m) : (c < st);
    endfunction

    function automatic mdl_t mdl_next(mdl_t cur, int m, int st, bit r, bit ld,
                                      bit en, bit cin, bit up, int din);
        mdl_t n;
        bit   b;
        n.cnt  = cur.cnt;
        n.wrap = 1'b0;
        n.lerr = 1'b0;
        b = mdl_tc(cur.cnt, m, st, up);
        if (r) begin
            n.cnt = 0;
        end else if (ld) begin
            if (din >= m) begin
                n.cnt  = m - 1;
                n.lerr = 1'b1;
            end else begin
                n.cnt = din;
            end
        end else if (en && cin) begin
            n.wrap = b;
`ifdef MODN_CNT_SATURATE_EN
            if (b) n.cnt = up ? m - 1 : 0;
            else   n.cnt = up ? cur.cnt + st : cur.cnt - st;
`else
            n.cnt = up ? (cur.cnt + st) % m : (cur.cnt - st + m) % m;
`endif
        end
        return n;
    endfunction

    task automatic check_dut(input string nm, input mdl_t md, input int m, input int st,
                             input bit en, input bit cin, input bit mode, input int cnt,
                             input bit wr, input bit le, input bit tc, input bit co);
        bit etc;
        etc = mdl_tc(md.cnt, m, st, mode);
        check_val({nm, ".count"}, cnt, md.cnt);
        check_val({nm, ".wrap"}, wr, md.wrap);
        check_val({nm, ".load_err"}, le, md.lerr);
        check_val({nm, ".tc"}, tc, etc);
        check_val({nm, ".co"}, co, en & cin & etc);
    endtask

    task automatic tick();
        bit lo_co;
        lo_co = i_lo.en & i_lo.cin & mdl_tc(mlo.cnt, 10, 1, i_lo.mode);
        @(posedge clk);
        m13 = mdl_next(m13, 13, 1, rst, i13.load, i13.en, i13.cin, i13.mode, int'(i13.data_in));
        m10 = mdl_next(m10, 10, 3, rst, i10.load, i10.en, i10.cin, i10.mode, int'(i10.data_in));
        mlo = mdl_next(mlo, 10, 1, rst, i_lo.load, i_lo.en, i_lo.cin, i_lo.mode, int'(i_lo.data_in));
        mhi = mdl_next(mhi, 6, 1, rst, i_hi.load, i_hi.en, lo_co, i_hi.mode, int'(i_hi.data_in));
        @(negedge clk);
        lo_co = i_lo.en & i_lo.cin & mdl_tc(mlo.cnt, 10, 1, i_lo.mode);
        check_dut("m13", m13, 13, 1, i13.en, i13.cin, i13.mode, int'(i13.count),
                  i13.wrap, i13.load_err, i13.tc, i13.co);
        check_dut("m10", m10, 10, 3, i10.en, i10.cin, i10.mode, int'(i10.count),
                  i10.wrap, i10.load_err, i10.tc, i10.co);
        check_dut("lo", mlo, 10, 1, i_lo.en, i_lo.cin, i_lo.mode, int'(i_lo.count),
                  i_lo.wrap, i_lo.load_err, i_lo.tc, i_lo.co);
        check_dut("hi", mhi, 6, 1, i_hi.en, lo_co, i_hi.mode, int'(i_hi.count),
                  i_hi.wrap, i_hi.load_err, i_hi.tc, i_hi.co);
    endtask

    initial begin
        // Reset with a competing load: reset must win.
        rst = 1'b1;
        i13.en = 1'b0;  i13.cin = 1'b1;  i13.load = 1'b1;  i13.mode = 1'b1;  i13.data_in = 4'd5;
        i10.en = 1'b0;  i10.cin = 1'b1;  i10.load = 1'b1;  i10.mode = 1'b1;  i10.data_in = 4'd5;
        i_lo.en = 1'b0; i_lo.cin = 1'b1; i_lo.load = 1'b1; i_lo.mode = 1'b1; i_lo.data_in = 4'd5;
        i_hi.en = 1'b0; i_hi.load = 1'b1; i_hi.mode = 1'b1; i_hi.data_in = 3'd5;
        tick();
        check_val("rst_count", i13.count, 0);
        check_val("rst_wrap", i13.wrap, 0);
        check_val("rst_load_err", i13.load_err, 0);

        rst = 1'b0;
        i10.load = 1'b0; i_lo.load = 1'b0; i_hi.load = 1'b0;
        i13.data_in = 4'd7;
        tick();
        check_val("load7", i13.count, 7);

        // Mod-13 up through the wrap.
        i13.data_in = 4'd11;
        tick();
        i13.load = 1'b0; i13.en = 1'b1; i13.mode = 1'b1;
        tick();
        check_val("up_12", i13.count, 12);
        check_val("up_tc", i13.tc, 1);
        check_val("up_co", i13.co, 1);
        tick();
`ifdef MODN_CNT_SATURATE_EN
        check_val("up_sat", i13.count, 12);
`else
        check_val("up_wrap_cnt", i13.count, 0);
`endif
        check_val("up_wrap_pulse", i13.wrap, 1);
        tick();

        // Mod-13 down through the wrap, then reverse direction.
        i13.load = 1'b1; i13.data_in = 4'd1; i13.en = 1'b0;
        tick();
        i13.load = 1'b0; i13.en = 1'b1; i13.mode = 1'b0;
        tick();
        check_val("dn_0", i13.count, 0);
        check_val("dn_tc", i13.tc, 1);
        tick();
`ifdef MODN_CNT_SATURATE_EN
        check_val("dn_sat", i13.count, 0);
`else
        check_val("dn_wrap_cnt", i13.count, 12);
`endif
        check_val("dn_wrap_pulse", i13.wrap, 1);
        i13.mode = 1'b1;
        tick();
        i13.en = 1'b0;

        // Mod-10, step 3.
        i10.load = 1'b1; i10.data_in = 4'd8;
        tick();
        i10.load = 1'b0; i10.en = 1'b1; i10.mode = 1'b1;
        tick();
`ifdef MODN_CNT_SATURATE_EN
        check_val("s3_up", i10.count, 9);
`else
        check_val("s3_up", i10.count, 1);
`endif
        check_val("s3_up_wrap", i10.wrap, 1);
        i10.load = 1'b1; i10.data_in = 4'd2; i10.en = 1'b0;
        tick();
        i10.load = 1'b0; i10.en = 1'b1; i10.mode = 1'b0;
        tick();
`ifdef MODN_CNT_SATURATE_EN
        check_val("s3_dn", i10.count, 0);
`else
        check_val("s3_dn", i10.count, 9);
`endif
        i10.load = 1'b1; i10.data_in = 4'd14;
        tick();
        check_val("oor_count", i10.count, 9);
        check_val("oor_err", i10.load_err, 1);
        i10.load = 1'b0; i10.en = 1'b0;
        tick();
        check_val("oor_err_clr", i10.load_err, 0);

        // Cascade mod-10 low / mod-6 high.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_lo.en = 1'b1; i_lo.cin = 1'b1; i_lo.mode = 1'b1;
        i_hi.en = 1'b1; i_hi.mode = 1'b1;
        repeat (59) tick();
        check_val("casc59_lo", i_lo.count, 9);
        check_val("casc59_hi", i_hi.count, 5);
        tick();
`ifdef MODN_CNT_SATURATE_EN
        check_val("casc60_lo", i_lo.count, 9);
        check_val("casc60_hi", i_hi.count, 5);
`else
        check_val("casc60_lo", i_lo.count, 0);
        check_val("casc60_hi", i_hi.count, 0);
`endif
        check_val("casc60_lo_wrap", i_lo.wrap, 1);
        check_val("casc60_hi_wrap", i_hi.wrap, 1);
        tick();
        i_lo.en = 1'b0;
        tick();
        i_lo.en = 1'b1; i_lo.cin = 1'b0;
        tick();

        // Random traffic on every instance.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            i13.load = ($urandom_range(7) == 0);  i13.en = ($urandom_range(3) != 0);
            i13.cin = ($urandom_range(7) != 0);   i13.mode = 1'($urandom);
            i13.data_in = 4'($urandom);
            i10.load = ($urandom_range(7) == 0);  i10.en = ($urandom_range(3) != 0);
            i10.cin = ($urandom_range(7) != 0);   i10.mode = 1'($urandom);
            i10.data_in = 4'($urandom);
            i_lo.load = ($urandom_range(15) == 0); i_lo.en = ($urandom_range(3) != 0);
            i_lo.cin = ($urandom_range(7) != 0);   i_lo.mode = 1'($urandom);
            i_lo.data_in = 4'($urandom);
            i_hi.load = ($urandom_range(15) == 0); i_hi.en = ($urandom_range(3) != 0);
            i_hi.mode = 1'($urandom);
            i_hi.data_in = 3'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
